// File: rtl/cnt1_arbiter.sv
// Round-robin vector arbiter in front of a shared cnt1 popcount pipeline.
// Grants whole vectors, tags each with its source ID, and routes returned counts back in order.
module cnt1_arbiter #(
  parameter int unsigned BUS_WIDTH     = 512,
  parameter int unsigned SUB_VECTOR_NO = 2,
  parameter int unsigned CNT_WIDTH     = 10,
  parameter int unsigned TAG_DEPTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] i_S0Data,
  input  logic                 i_S0Valid,
  output logic                 o_S0Ready,
  input  logic [BUS_WIDTH-1:0] i_S1Data,
  input  logic                 i_S1Valid,
  output logic                 o_S1Ready,
  output logic [BUS_WIDTH-1:0] o_Vector,
  output logic                 o_Valid,
  input  logic [CNT_WIDTH-1:0] i_Cnt,
  input  logic                 i_CntDone,
  output logic [CNT_WIDTH-1:0] o_Cnt,
  output logic                 o_Cnt0Valid,
  output logic                 o_Cnt1Valid,
  output logic                 o_Err
);

  localparam int unsigned WC_W  = (SUB_VECTOR_NO > 1) ? $clog2(SUB_VECTOR_NO) : 1;
  localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned RM_W  = OCC_W + 1;
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(SUB_VECTOR_NO - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [WC_W-1:0]        wcnt_q, wcnt_d;
  logic                   prio_q, prio_d;
  logic [TAG_DEPTH-1:0]   tag_q;
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]       occ_q;

  logic                   gnt_valid, gnt_id;
  logic                   pop, push_pend, room;
  logic                   elig0, elig1, arb_en;
  logic                   win_valid, win_id;
  logic                   acc, acc_id, push, last_acc;
  logic                   s0_rdy, s1_rdy;
  logic [BUS_WIDTH-1:0]   acc_data;

  // Arbitration, acceptance and next-state logic
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    prio_d    = prio_q;
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    win_valid = 1'b0;
    win_id    = prio_q;
    s0_rdy    = 1'b0;
    s1_rdy    = 1'b0;
    acc       = 1'b0;
    acc_id    = 1'b0;

    case (state_q)
      GNT0: begin
        gnt_valid = i_S0Valid;
        gnt_id    = 1'b0;
      end
      GNT1: begin
        gnt_valid = i_S1Valid;
        gnt_id    = 1'b1;
      end
      default: ;
    endcase

    // Room accounts for a first word being pushed by the held grant this same cycle
    pop       = i_CntDone && (occ_q != '0);
    push_pend = gnt_valid && (wcnt_q == '0);
    room      = (({1'b0, occ_q} + RM_W'(push_pend)) - RM_W'(pop)) < RM_W'(TAG_DEPTH);
    elig0     = i_S0Valid && room;
    elig1     = i_S1Valid && room;
    arb_en    = (state_q == IDLE) || (gnt_valid && (wcnt_q == LAST_WORD));

    if (arb_en) begin
      if (elig0 && elig1) begin
        win_valid = 1'b1;
        win_id    = prio_q;
      end else if (elig0) begin
        win_valid = 1'b1;
        win_id    = 1'b0;
      end else if (elig1) begin
        win_valid = 1'b1;
        win_id    = 1'b1;
      end
    end

    // A winner picked during a last-word cycle takes the bus on the following cycle
    if (state_q == IDLE) begin
      acc    = win_valid;
      acc_id = win_id;
      s0_rdy = win_valid && !win_id;
      s1_rdy = win_valid && win_id;
    end else begin
      acc    = gnt_valid;
      acc_id = gnt_id;
      s0_rdy = (state_q == GNT0);
      s1_rdy = (state_q == GNT1);
    end

    push     = acc && (wcnt_q == '0);
    last_acc = acc && (wcnt_q == LAST_WORD);
    acc_data = acc_id ? i_S1Data : i_S0Data;

    if (acc) wcnt_d = last_acc ? '0 : wcnt_q + WC_W'(1);
    if (win_valid) prio_d = ~win_id;

    if (state_q == IDLE) begin
      if (acc && !last_acc) state_d = win_id ? GNT1 : GNT0;
    end else if (last_acc) begin
      state_d = win_valid ? (win_id ? GNT1 : GNT0) : IDLE;
    end
  end

  assign o_S0Ready = s0_rdy && !rst;
  assign o_S1Ready = s1_rdy && !rst;

  // FSM and arbitration state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      prio_q  <= prio_d;
    end
  end

  // Source-ID tag FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        tag_q[wr_ptr_q] <= acc_id;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      occ_q <= (occ_q + OCC_W'(push)) - OCC_W'(pop);
    end
  end

  // Forward path to cnt1 and return path to the sources
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_Vector    <= '0;
      o_Valid     <= 1'b0;
      o_Cnt       <= '0;
      o_Cnt0Valid <= 1'b0;
      o_Cnt1Valid <= 1'b0;
      o_Err       <= 1'b0;
    end else begin
      o_Valid <= acc;
      if (acc) o_Vector <= acc_data;
      o_Cnt0Valid <= pop && !tag_q[rd_ptr_q];
      o_Cnt1Valid <= pop && tag_q[rd_ptr_q];
      if (pop) o_Cnt <= i_Cnt;
      if (i_CntDone && (occ_q == '0)) o_Err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cnt1_arbiter.sv
// Directed bench for cnt1_arbiter: one instance with a deep tag FIFO, one with TAG_DEPTH=2.
module tb_cnt1_arbiter;

  localparam int unsigned BW  = 16;
  localparam int unsigned SVN = 2;
  localparam int unsigned CW  = 6;

  logic          clk = 1'b0;
  logic          rst;

  logic [BW-1:0] s0_data, s1_data, o_vec;
  logic          s0_valid, s1_valid, s0_ready, s1_ready, o_valid;
  logic [CW-1:0] cnt, o_cnt;
  logic          cnt_done, c0v, c1v, err;

  logic [BW-1:0] b_s0_data, b_s1_data, b_vec;
  logic          b_s0_valid, b_s1_valid, b_s0_ready, b_s1_ready, b_valid;
  logic [CW-1:0] b_cnt, b_ocnt;
  logic          b_done, b_c0v, b_c1v, b_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cnt1_arbiter #(.BUS_WIDTH(BW), .SUB_VECTOR_NO(SVN), .CNT_WIDTH(CW), .TAG_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .i_S0Data(s0_data), .i_S0Valid(s0_valid), .o_S0Ready(s0_ready),
    .i_S1Data(s1_data), .i_S1Valid(s1_valid), .o_S1Ready(s1_ready),
    .o_Vector(o_vec), .o_Valid(o_valid),
    .i_Cnt(cnt), .i_CntDone(cnt_done),
    .o_Cnt(o_cnt), .o_Cnt0Valid(c0v), .o_Cnt1Valid(c1v), .o_Err(err)
  );

  cnt1_arbiter #(.BUS_WIDTH(BW), .SUB_VECTOR_NO(SVN), .CNT_WIDTH(CW), .TAG_DEPTH(2)) dut_b (
    .clk(clk), .rst(rst),
    .i_S0Data(b_s0_data), .i_S0Valid(b_s0_valid), .o_S0Ready(b_s0_ready),
    .i_S1Data(b_s1_data), .i_S1Valid(b_s1_valid), .o_S1Ready(b_s1_ready),
    .o_Vector(b_vec), .o_Valid(b_valid),
    .i_Cnt(b_cnt), .i_CntDone(b_done),
    .o_Cnt(b_ocnt), .o_Cnt0Valid(b_c0v), .o_Cnt1Valid(b_c1v), .o_Err(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    s0_data = '0; s1_data = '0; cnt = '0; cnt_done = 1'b0;
    s0_valid = 1'b1; s1_valid = 1'b1;
    b_s0_data = '0; b_s1_data = '0; b_s0_valid = 1'b0; b_s1_valid = 1'b0;
    b_cnt = '0; b_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, readies held low even with valids up
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_vector", 32'(o_vec), 32'd0);
    chk("rst_cnt", 32'(o_cnt), 32'd0);
    chk("rst_c0v", 32'(c0v), 32'd0);
    chk("rst_c1v", 32'(c1v), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_s0_ready", 32'(s0_ready), 32'd0);
    chk("rst_s1_ready", 32'(s1_ready), 32'd0);
    s0_valid = 1'b0; s1_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Test 1: S0 alone, three back-to-back vectors
    s0_valid = 1'b1;
    chk("t1_valid_before", 32'(o_valid), 32'd0);
    for (int k = 0; k < 6; k++) begin
      s0_data = BW'(32'hA000 + k);
      #1;
      chk("t1_s0_ready", 32'(s0_ready), 32'd1);
      chk("t1_s1_ready", 32'(s1_ready), 32'd0);
      tick();
      chk("t1_valid", 32'(o_valid), 32'd1);
      chk("t1_vector", 32'(o_vec), 32'hA000 + 32'(k));
    end
    s0_valid = 1'b0;
    tick();
    chk("t1_valid_end", 32'(o_valid), 32'd0);
    chk("t1_vector_hold", 32'(o_vec), 32'hA005);

    cnt_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cnt = CW'(5 + 2 * i);
      tick();
      chk("t1_c0v", 32'(c0v), 32'd1);
      chk("t1_c1v", 32'(c1v), 32'd0);
      chk("t1_cnt", 32'(o_cnt), 32'(5 + 2 * i));
    end
    cnt_done = 1'b0;
    tick();
    chk("t1_c0v_end", 32'(c0v), 32'd0);
    chk("t1_err", 32'(err), 32'd0);

    // Test 2: both sources continuously valid, vectors alternate S0,S1,S0,S1
    s0_valid = 1'b1; s1_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s0_data = BW'(32'h5000 + k);
      s1_data = BW'(32'h6000 + k);
      if (k == 7) s0_valid = 1'b0;
      #1;
      chk("t2_s0_ready", 32'(s0_ready), 32'(((k / 2) % 2) == 0));
      chk("t2_s1_ready", 32'(s1_ready), 32'(((k / 2) % 2) == 1));
      tick();
      chk("t2_valid", 32'(o_valid), 32'd1);
      chk("t2_vector", 32'(o_vec), (((k / 2) % 2) == 0) ? 32'h5000 + 32'(k) : 32'h6000 + 32'(k));
    end
    s1_valid = 1'b0;
    tick();
    chk("t2_valid_end", 32'(o_valid), 32'd0);

    cnt_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cnt = CW'(11 + i);
      tick();
      chk("t2_c0v", 32'(c0v), 32'((i % 2) == 0));
      chk("t2_c1v", 32'(c1v), 32'((i % 2) == 1));
      chk("t2_cnt", 32'(o_cnt), 32'(11 + i));
    end
    cnt_done = 1'b0;

    // Test 3: S1 stalls three cycles mid-vector; S0 stays locked out
    s0_valid = 1'b1; s1_valid = 1'b1;
    s0_data = BW'(32'h7777); s1_data = BW'(32'h7000);
    #1;
    chk("t3_s0_ready_w0", 32'(s0_ready), 32'd0);
    chk("t3_s1_ready_w0", 32'(s1_ready), 32'd1);
    tick();
    chk("t3_valid_w0", 32'(o_valid), 32'd1);
    chk("t3_vector_w0", 32'(o_vec), 32'h7000);
    s1_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("t3_s0_ready_stall", 32'(s0_ready), 32'd0);
      tick();
      chk("t3_valid_gap", 32'(o_valid), 32'd0);
      chk("t3_vector_hold", 32'(o_vec), 32'h7000);
    end
    s1_valid = 1'b1; s1_data = BW'(32'h7001);
    #1;
    chk("t3_s0_ready_w1", 32'(s0_ready), 32'd0);
    tick();
    chk("t3_valid_w1", 32'(o_valid), 32'd1);
    chk("t3_vector_w1", 32'(o_vec), 32'h7001);
    s0_valid = 1'b0; s1_valid = 1'b0;
    tick();
    chk("t3_valid_end", 32'(o_valid), 32'd0);
    cnt = CW'(15); cnt_done = 1'b1;
    tick();
    cnt_done = 1'b0;
    chk("t3_c1v", 32'(c1v), 32'd1);
    chk("t3_c0v", 32'(c0v), 32'd0);
    chk("t3_cnt", 32'(o_cnt), 32'd15);

    // Test 5: count returned with nothing in flight
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("t5_err_clear", 32'(err), 32'd0);
    cnt = CW'(3); cnt_done = 1'b1;
    tick();
    cnt_done = 1'b0;
    chk("t5_err_set", 32'(err), 32'd1);
    chk("t5_c0v", 32'(c0v), 32'd0);
    chk("t5_c1v", 32'(c1v), 32'd0);
    repeat (3) tick();
    chk("t5_err_sticky", 32'(err), 32'd1);
    chk("t5_c0v_quiet", 32'(c0v), 32'd0);

    // Test 6: reset after word 0 of an S0 vector, then S1 alone
    s0_valid = 1'b1; s0_data = BW'(32'hAAAA);
    #1;
    chk("t6_s0_ready", 32'(s0_ready), 32'd1);
    tick();
    chk("t6_valid_w0", 32'(o_valid), 32'd1);
    s0_data = BW'(32'hBBBB);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(o_valid), 32'd0);
    chk("t6_rst_vector", 32'(o_vec), 32'd0);
    chk("t6_rst_s0_ready", 32'(s0_ready), 32'd0);
    chk("t6_rst_err", 32'(err), 32'd0);
    chk("t6_rst_c0v", 32'(c0v), 32'd0);
    s0_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    s1_valid = 1'b1; s1_data = BW'(32'h8000);
    #1;
    chk("t6_s1_ready", 32'(s1_ready), 32'd1);
    tick();
    chk("t6_vector_w0", 32'(o_vec), 32'h8000);
    s1_data = BW'(32'h8001);
    tick();
    chk("t6_vector_w1", 32'(o_vec), 32'h8001);
    s1_valid = 1'b0;
    tick();
    cnt = CW'(21); cnt_done = 1'b1;
    tick();
    cnt_done = 1'b0;
    chk("t6_c1v", 32'(c1v), 32'd1);
    chk("t6_c0v", 32'(c0v), 32'd0);
    chk("t6_cnt", 32'(o_cnt), 32'd21);

    // Test 4: TAG_DEPTH=2 fills, then one pop lets exactly one more vector in
    b_s0_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      b_s0_data = BW'(32'h9000 + k);
      #1;
      chk("t4_ready_fill", 32'(b_s0_ready), 32'd1);
      tick();
      chk("t4_valid_fill", 32'(b_valid), 32'd1);
      chk("t4_vector_fill", 32'(b_vec), 32'h9000 + 32'(k));
    end
    for (int j = 0; j < 2; j++) begin
      #1;
      chk("t4_ready_full", 32'(b_s0_ready), 32'd0);
      tick();
      chk("t4_valid_full", 32'(b_valid), 32'd0);
    end
    b_s0_data = BW'(32'h9004); b_cnt = CW'(3); b_done = 1'b1;
    #1;
    chk("t4_ready_pop", 32'(b_s0_ready), 32'd1);
    tick();
    b_done = 1'b0;
    chk("t4_valid_w0", 32'(b_valid), 32'd1);
    chk("t4_vector_w0", 32'(b_vec), 32'h9004);
    chk("t4_c0v", 32'(b_c0v), 32'd1);
    chk("t4_cnt", 32'(b_ocnt), 32'd3);
    b_s0_data = BW'(32'h9005);
    #1;
    chk("t4_ready_w1", 32'(b_s0_ready), 32'd1);
    tick();
    chk("t4_vector_w1", 32'(b_vec), 32'h9005);
    b_s0_data = BW'(32'h9006);
    #1;
    chk("t4_ready_refull", 32'(b_s0_ready), 32'd0);
    tick();
    chk("t4_valid_refull", 32'(b_valid), 32'd0);
    chk("t4_err", 32'(b_err), 32'd0);
    b_s0_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
